// File: rtl/cpu_timing.sv
// CPU bus timing for the PET core: splits each 1 us slot into CPU cycles at 1/2/4/8 MHz
// and hands each cycle to either the 6502 or the DMA master.
module cpu_timing #(
    parameter int CLK_MHZ = 64
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [1:0] speed_i,
    input  logic       dma_req_i,
    output logic       slot_start_o,
    output logic       cpu_start_o,
    output logic       cpu_be_o,
    output logic       cpu_phi2_o,
    output logic       cpu_done_o,
    output logic       dma_grant_o
);

    localparam int CW = $clog2(CLK_MHZ);

    if (CLK_MHZ < 16 || (CLK_MHZ & (CLK_MHZ - 1)) != 0) begin : g_bad_clk
        $error("cpu_timing: CLK_MHZ must be a power of two and at least 16");
    end

    // Mask of N-1 for the cycle length N = CLK_MHZ >> spd; position is cnt & mask.
    function automatic logic [CW-1:0] cycle_mask(input logic [1:0] spd);
        case (spd)
            2'd0:    return CW'(CLK_MHZ - 1);
            2'd1:    return CW'(CLK_MHZ / 2 - 1);
            2'd2:    return CW'(CLK_MHZ / 4 - 1);
            default: return CW'(CLK_MHZ / 8 - 1);
        endcase
    endfunction

    logic [CW-1:0] cnt;
    logic [1:0]    speed_r;
    logic          cpu_owns;
    logic          started;

    logic [CW-1:0] cnt_nxt;
    logic [1:0]    speed_nxt;
    logic [CW-1:0] mask_nxt;
    logic [CW-1:0] pos_nxt;
    logic          owns_nxt;
    logic          started_nxt;
    logic          cycle_start_nxt;

    always_comb begin
        cnt_nxt         = cnt + CW'(1);
        speed_nxt       = (cnt_nxt == '0) ? speed_i : speed_r;
        mask_nxt        = cycle_mask(speed_nxt);
        pos_nxt         = cnt_nxt & mask_nxt;
        cycle_start_nxt = (pos_nxt == '0);
        owns_nxt        = cycle_start_nxt ? !dma_req_i : cpu_owns;
        started_nxt     = started | cycle_start_nxt;
    end

    // Outputs are registered from the next-state values so they line up with cnt on the same edge.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt          <= CW'(CLK_MHZ - 1);
            speed_r      <= 2'd0;
            cpu_owns     <= 1'b0;
            started      <= 1'b0;
            slot_start_o <= 1'b0;
            cpu_start_o  <= 1'b0;
            cpu_be_o     <= 1'b0;
            cpu_phi2_o   <= 1'b0;
            cpu_done_o   <= 1'b0;
            dma_grant_o  <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            speed_r      <= speed_nxt;
            cpu_owns     <= owns_nxt;
            started      <= started_nxt;
            slot_start_o <= (cnt_nxt == '0);
            cpu_start_o  <= cycle_start_nxt;
            cpu_be_o     <= owns_nxt;
            cpu_phi2_o   <= owns_nxt && (pos_nxt >= ((mask_nxt >> 1) + CW'(1)));
            cpu_done_o   <= owns_nxt && (pos_nxt == mask_nxt);
            dma_grant_o  <= started_nxt && !owns_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_timing.sv
// Directed bench for cpu_timing at CLK_MHZ = 64: checkpoint table plus reset and per-slot count sequences.
module tb_cpu_timing;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] speed = 2'd0;
    logic       dma_req = 1'b0;
    logic       slot_start, cpu_start, cpu_be, cpu_phi2, cpu_done, dma_grant;

    int checks = 0;
    int errors = 0;
    int ecnt;

    cpu_timing #(.CLK_MHZ(64)) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .speed_i      (speed),
        .dma_req_i    (dma_req),
        .slot_start_o (slot_start),
        .cpu_start_o  (cpu_start),
        .cpu_be_o     (cpu_be),
        .cpu_phi2_o   (cpu_phi2),
        .cpu_done_o   (cpu_done),
        .dma_grant_o  (dma_grant)
    );

    always #5 clk = ~clk;

    // Edge number since reset release; edge 1 is the first edge with reset low.
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    logic [5:0] outs;
    assign outs = {slot_start, cpu_start, cpu_be, cpu_phi2, cpu_done, dma_grant};

    task automatic chk(input string nm, input logic [5:0] exp);
        checks++;
        if (outs !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (slot,start,be,phi2,done,dma)", nm, outs, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    task automatic goto_edge(input int e);
        while (ecnt < e) @(negedge clk);
    endtask

    // Per-slot tallies over the 8 MHz slot (edges 129..192) plus bus invariants on every clock.
    int n_slot = 0, n_start = 0, n_done = 0, n_phi2 = 0;
    always @(negedge clk) begin
        if (!rst && ecnt >= 1) begin
            if (ecnt >= 129 && ecnt <= 192) begin
                n_slot  = n_slot + int'(slot_start);
                n_start = n_start + int'(cpu_start);
                n_done  = n_done + int'(cpu_done);
                n_phi2  = n_phi2 + int'(cpu_phi2);
            end
            checks++;
            if (cpu_be && dma_grant) begin
                errors++;
                $display("FAIL be_dma_exclusive: edge %0d be=%b dma=%b required not both 1", ecnt, cpu_be, dma_grant);
            end
            checks++;
            if (cpu_phi2 && !cpu_be) begin
                errors++;
                $display("FAIL phi2_in_dma: edge %0d phi2=%b be=%b required phi2=0", ecnt, cpu_phi2, cpu_be);
            end
        end
    end

    typedef struct {
        int         e;
        logic [5:0] exp;
        int         spd;
        int         dma;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // {edge, {slot,start,be,phi2,done,dma}, speed to apply after, dma_req to apply after}; -1 = keep
        tbl = '{
            '{1,   6'b111000, -1, -1}, '{32,  6'b001000, -1, -1}, '{33,  6'b001100, -1, -1},
            '{64,  6'b001110, -1, -1}, '{65,  6'b111000, -1, -1}, '{97,  6'b001100, -1, -1},
            '{100, 6'b001100,  3, -1}, '{105, 6'b001100, -1, -1}, '{128, 6'b001110, -1, -1},
            '{129, 6'b111000, -1, -1}, '{133, 6'b001100, -1, -1}, '{136, 6'b001110, -1, -1},
            '{137, 6'b011000, -1, -1}, '{150, 6'b001100,  0, -1}, '{192, 6'b001110, -1, -1},
            '{193, 6'b111000, -1, -1}, '{203, 6'b001000,  2, -1}, '{209, 6'b001000, -1, -1},
            '{256, 6'b001110, -1, -1}, '{257, 6'b111000, -1, -1}, '{265, 6'b001100, -1, -1},
            '{272, 6'b001110, -1, -1}, '{273, 6'b011000,  1, -1}, '{320, 6'b001110, -1, -1},
            '{321, 6'b111000, -1, -1}, '{337, 6'b001100, -1, -1}, '{352, 6'b001110, -1,  1},
            '{353, 6'b010001, -1,  0}, '{370, 6'b000001, -1, -1}, '{384, 6'b000001, -1, -1},
            '{385, 6'b111000, -1, -1}, '{390, 6'b001000, -1,  1}, '{391, 6'b001000, -1, -1},
            '{416, 6'b001110, -1, -1}, '{417, 6'b010001, -1, -1}, '{422, 6'b000001, -1,  0},
            '{423, 6'b000001, -1, -1}, '{448, 6'b000001, -1, -1}, '{449, 6'b111000,  0, -1},
            '{512, 6'b001110, -1, -1}, '{513, 6'b111000, -1, -1}, '{553, 6'b001100, -1, -1}
        };

        repeat (3) @(negedge clk);
        chk("reset_hold", 6'b000000);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            goto_edge(tbl[i].e);
            chk($sformatf("edge%0d", tbl[i].e), tbl[i].exp);
            if (tbl[i].spd >= 0) speed = 2'(tbl[i].spd);
            if (tbl[i].dma >= 0) dma_req = tbl[i].dma[0];
        end

        chk_int("slot8_slot_count", n_slot, 1);
        chk_int("slot8_start_count", n_start, 8);
        chk_int("slot8_done_count", n_done, 8);
        chk_int("slot8_phi2_clocks", n_phi2, 32);

        // Mid-cycle reset at cnt = 40 with phi2 high: outputs must drop before any clock edge.
        #1 rst = 1'b1;
        #1 chk("async_reset", 6'b000000);
        @(posedge clk);
        #1 chk("reset_edge", 6'b000000);
        speed = 2'd0;
        @(negedge clk);
        rst = 1'b0;
        goto_edge(1);
        chk("rst2_edge1", 6'b111000);
        goto_edge(33);
        chk("rst2_edge33", 6'b001100);
        goto_edge(64);
        chk("rst2_edge64", 6'b001110);
        goto_edge(65);
        chk("rst2_edge65", 6'b111000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
